// File: rtl/sabana_vec_pkg.sv
// Shared types for the vector-scalar engine: operation codes and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package sabana_vec_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_MAX = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sabana_vec_alu.sv
// Element-wise combine of b with scalar a: wrapping add/sub, low-half multiply, signed max.
// Latency: purely combinational.
// Backpressure: none; the result follows the inputs.
module sabana_vec_alu
  import sabana_vec_pkg::*;
#(
  parameter int DW = 32
) (
  input  op_t           op,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] a,
  output logic [DW-1:0] y
);

  // A DW-wide product keeps only the low DW bits, which is the required result.
  logic [DW-1:0] mul_dat;
  assign mul_dat = b * a;

  // Select the operation result; signed comparison for MAX.
  always_comb begin
    y = '0;
    unique case (op)
      OP_ADD: y = b + a;
      OP_SUB: y = b - a;
      OP_MUL: y = mul_dat;
      OP_MAX: y = ($signed(b) > $signed(a)) ? b : a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/sabana_vec_scalar_op.sv
// Reads len elements of b, combines each with latched scalar a, writes the results to y.
// Latency: one element every RD_LAT+1 cycles; finish rises the cycle after the last write.
// Backpressure: none; start is a level, sampled only in IDLE, and finish holds until start drops.
module sabana_vec_scalar_op
  import sabana_vec_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 6,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          finish,
  input  logic [1:0]    op,
  input  logic [AW:0]   len,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] y_base,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [AW-1:0] b_addr,
  output logic [DW-1:0] y_out,
  output logic [AW-1:0] y_addr,
  output logic          y_we
);

  localparam int           DEPTH   = 2 ** AW;
  localparam int           LW      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [AW:0]  DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW:0]  ONE_L   = (AW + 1)'(1);
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [LW-1:0] lat_q, lat_d;
  op_t           op_q, op_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] b_base_q, b_base_d;
  logic [AW-1:0] y_base_q, y_base_d;
  logic [DW-1:0] a_q, a_d;

  logic [AW:0]   len_clamped;
  logic          last_elem;
  logic [DW-1:0] alu_y;

  // Oversized lengths saturate at one full pass over the RAM.
  assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
  assign last_elem   = ({1'b0, idx_q} == (len_q - ONE_L));

  sabana_vec_alu #(
    .DW(DW)
  ) u_alu (
    .op(op_q),
    .b (b_in),
    .a (a_q),
    .y (alu_y)
  );

  // State register plus the operands captured when a run is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      lat_q    <= '0;
      op_q     <= OP_ADD;
      len_q    <= '0;
      b_base_q <= '0;
      y_base_q <= '0;
      a_q      <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lat_q    <= lat_d;
      op_q     <= op_d;
      len_q    <= len_d;
      b_base_q <= b_base_d;
      y_base_q <= y_base_d;
      a_q      <= a_d;
    end
  end

  // Next-state, counters and outputs; addresses hold through READ and WRITE of one element.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lat_d    = lat_q;
    op_d     = op_q;
    len_d    = len_q;
    b_base_d = b_base_q;
    y_base_d = y_base_q;
    a_d      = a_q;
    finish   = 1'b0;
    y_we     = 1'b0;
    b_addr   = '0;
    y_addr   = '0;
    y_out    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d     = op_t'(op);
          len_d    = len_clamped;
          b_base_d = b_base;
          y_base_d = y_base;
          a_d      = a_in;
          idx_d    = '0;
          lat_d    = '0;
          state_d  = (len_clamped == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        b_addr = b_base_q + idx_q;
        y_addr = y_base_q + idx_q;
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = ST_WRITE;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      ST_WRITE: begin
        b_addr = b_base_q + idx_q;
        y_addr = y_base_q + idx_q;
        y_we   = 1'b1;
        y_out  = alu_y;
        if (last_elem) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        finish = 1'b1;
        if (!start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
